// File: rtl/mem_arbiter.sv
// Two-requester, round-robin memory arbiter.
// Fixed three-state access cycle: grant/drive memory, capture read data, respond.
module mem_arbiter (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic [7:0] addr0_i,
    input  logic [7:0] addr1_i,
    input  logic [7:0] wdata0_i,
    input  logic [7:0] wdata1_i,
    input  logic       wr0_i,
    input  logic       wr1_i,
    output logic       gnt0_o,
    output logic       gnt1_o,
    output logic       done0_o,
    output logic       done1_o,
    output logic [7:0] rdata_o,
    output logic [7:0] mem_addr_o,
    output logic [7:0] mem_wdata_o,
    output logic       mem_we_o,
    input  logic [7:0] mem_rdata_i,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e     state_q;
    logic       last_q;
    logic       id_q;
    logic       wr_q;
    logic       gnt0_q, gnt1_q, done0_q, done1_q, mem_we_q;
    logic [7:0] mem_addr_q, mem_wdata_q, rdata_q;
    logic       win_d;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        win_d = 1'b0;
        if (req0_i && req1_i) begin
            win_d = ~last_q;
        end else if (req1_i) begin
            win_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            wr_q        <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0_i || req1_i) begin
                        state_q     <= ACCESS;
                        id_q        <= win_d;
                        last_q      <= win_d;
                        wr_q        <= win_d ? wr1_i    : wr0_i;
                        mem_we_q    <= win_d ? wr1_i    : wr0_i;
                        mem_addr_q  <= win_d ? addr1_i  : addr0_i;
                        mem_wdata_q <= win_d ? wdata1_i : wdata0_i;
                        gnt0_q      <= ~win_d;
                        gnt1_q      <= win_d;
                    end
                end
                ACCESS: begin
                    state_q <= RESP;
                    if (!wr_q) begin
                        rdata_q <= mem_rdata_i;
                    end
                    done0_q <= ~id_q;
                    done1_q <= id_q;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt0_o      = gnt0_q;
    assign gnt1_o      = gnt1_q;
    assign done0_o     = done0_q;
    assign done1_o     = done1_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a combinational-read memory model.
// Unwritten locations read back as (address ^ 8'hA5).
module tb_mem_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, req1, wr0, wr1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, mem_we, busy;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [5:0] st;

    bit   [7:0] mem [256];
    bit         written [256];

    int checks   = 0;
    int failures = 0;

    mem_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req0_i      (req0),
        .req1_i      (req1),
        .addr0_i     (addr0),
        .addr1_i     (addr1),
        .wdata0_i    (wdata0),
        .wdata1_i    (wdata1),
        .wr0_i       (wr0),
        .wr1_i       (wr1),
        .gnt0_o      (gnt0),
        .gnt1_o      (gnt1),
        .done0_o     (done0),
        .done1_o     (done1),
        .rdata_o     (rdata),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_we_o    (mem_we),
        .mem_rdata_i (mem_rdata),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign st        = {gnt0, gnt1, done0, done1, mem_we, busy};
    assign mem_rdata = written[mem_addr] ? mem[mem_addr] : (mem_addr ^ 8'hA5);

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
    end

    // Status vector order: {gnt0, gnt1, done0, done1, mem_we, busy}
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (st !== 6'b000000) begin
            failures++;
            $display("FAIL reset_status got=%b exp=000000", st);
        end
        checks++;
        if ({mem_addr, mem_wdata, rdata} !== 24'h000000) begin
            failures++;
            $display("FAIL reset_data got=%h exp=000000", {mem_addr, mem_wdata, rdata});
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        logic [5:0] exp_st [3] = '{6'b100011, 6'b001001, 6'b000000};
        req0 = 1'b1; wr0 = 1'b1; addr0 = 8'hF3; wdata0 = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) req0 = 1'b0;
            checks++;
            if (st !== exp_st[i]) begin
                failures++;
                $display("FAIL wr_status[%0d] got=%b exp=%b", i, st, exp_st[i]);
            end
            if (i == 0) begin
                checks++;
                if ({mem_addr, mem_wdata} !== 16'hF35A) begin
                    failures++;
                    $display("FAIL wr_bus got=%h exp=f35a", {mem_addr, mem_wdata});
                end
            end
        end
        req0 = 1'b1; wr0 = 1'b0; addr0 = 8'hF3;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) req0 = 1'b0;
            checks++;
            if (st !== (i == 0 ? 6'b100001 : (i == 1 ? 6'b001001 : 6'b000000))) begin
                failures++;
                $display("FAIL rd_status[%0d] got=%b", i, st);
            end
            if (i == 1) begin
                checks++;
                if (rdata !== 8'h5A) begin
                    failures++;
                    $display("FAIL rd_data got=%h exp=5a", rdata);
                end
            end
        end
    endtask

    task automatic test_tie;
        logic [5:0] exp_st [12] = '{
            6'b100001, 6'b001001, 6'b000000,
            6'b010001, 6'b000101, 6'b000000,
            6'b100001, 6'b001001, 6'b000000,
            6'b010001, 6'b000101, 6'b000000};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h20;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 8'h30;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 11) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            checks++;
            if (st !== exp_st[i]) begin
                failures++;
                $display("FAIL tie_status[%0d] got=%b exp=%b", i, st, exp_st[i]);
            end
            if (i == 1 || i == 4) begin
                checks++;
                if (rdata !== (i == 1 ? 8'h85 : 8'h95)) begin
                    failures++;
                    $display("FAIL tie_rdata[%0d] got=%h", i, rdata);
                end
            end
        end
    endtask

    task automatic test_stream;
        logic [7:0] exp_rd [4] = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
        req1 = 1'b1; wr1 = 1'b0; addr1 = 8'h10;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (st !== (i % 3 == 0 ? 6'b010001 : (i % 3 == 1 ? 6'b000101 : 6'b000000))) begin
                failures++;
                $display("FAIL stream_status[%0d] got=%b", i, st);
            end
            if (i % 3 == 0) begin
                checks++;
                if (mem_addr !== 8'h10 + 8'(i / 3)) begin
                    failures++;
                    $display("FAIL stream_addr[%0d] got=%h", i, mem_addr);
                end
                if (i == 9) req1 = 1'b0;
                else addr1 = addr1 + 8'd1;
            end
            if (i % 3 == 1) begin
                checks++;
                if (rdata !== exp_rd[i / 3]) begin
                    failures++;
                    $display("FAIL stream_rdata[%0d] got=%h exp=%h", i, rdata, exp_rd[i / 3]);
                end
            end
        end
    endtask

    task automatic test_late;
        logic [5:0] exp_st [9] = '{
            6'b100001, 6'b001001, 6'b000000,
            6'b010001, 6'b000101, 6'b000000,
            6'b100001, 6'b001001, 6'b000000};
        req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h40;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 0) begin
                req1 = 1'b1; wr1 = 1'b0; addr1 = 8'h41;
            end
            if (i == 3) req1 = 1'b0;
            if (i == 6) req0 = 1'b0;
            checks++;
            if (st !== exp_st[i]) begin
                failures++;
                $display("FAIL late_status[%0d] got=%b exp=%b", i, st, exp_st[i]);
            end
            if (i == 1 || i == 4) begin
                checks++;
                if (rdata !== (i == 1 ? 8'hE5 : 8'hE4)) begin
                    failures++;
                    $display("FAIL late_rdata[%0d] got=%h", i, rdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 8'h50; wdata0 = 8'hC3;
        tick();
        req0 = 1'b0;
        checks++;
        if (st !== 6'b100011) begin
            failures++;
            $display("FAIL rstw_access got=%b exp=100011", st);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (st !== 6'b000000 || {mem_addr, mem_wdata, rdata} !== 24'h000000) begin
            failures++;
            $display("FAIL rstw_async got=%b/%h exp=000000/000000", st, {mem_addr, mem_wdata, rdata});
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (st !== 6'b000000) begin
                failures++;
                $display("FAIL rstw_after[%0d] got=%b exp=000000", i, st);
            end
        end
        checks++;
        if (written[8'h50] !== 1'b0) begin
            failures++;
            $display("FAIL rstw_nowrite got=%b exp=0", written[8'h50]);
        end
    endtask

    task automatic test_withdrawn;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 8'h60;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin
                req1 = 1'b0;
                req0 = 1'b1; wr0 = 1'b1; addr0 = 8'h61; wdata0 = 8'h11;
            end
            if (i == 1) req0 = 1'b0;
            checks++;
            if (st !== (i == 0 ? 6'b010001 : (i == 1 ? 6'b000101 : 6'b000000))) begin
                failures++;
                $display("FAIL wd_status[%0d] got=%b", i, st);
            end
        end
        checks++;
        if (mem_addr !== 8'h60 || written[8'h61] !== 1'b0) begin
            failures++;
            $display("FAIL wd_noaccess got=%h/%b exp=60/0", mem_addr, written[8'h61]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        test_reset();
        test_write_read();
        test_tie();
        test_stream();
        test_late();
        test_reset_mid_write();
        test_withdrawn();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL run on one clock; reset is asynchronous and active-low.
REQ-002 clock  in  1  system clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous active-low reset; 0 forces the reset state immediately.
REQ-004 req0, req1  in  1 each  access request from requester 0 (CPU) and requester 1 (loader/debug port).
REQ-005 addr0, addr1  in  8 each  requested memory address.
REQ-006 wdata0, wdata1  in  8 each  write data, used only when the matching wr is 1.
REQ-007 wr0, wr1  in  1 each  1 = write, 0 = read.
REQ-008 gnt0, gnt1  out  1 each  one-cycle pulse: request accepted, address/data latched.
REQ-009 done0, done1  out  1 each  one-cycle pulse: access complete; rdata valid for reads.
REQ-010 rdata  out  8  read data, shared by both requesters, qualified by done0/done1.
REQ-011 mem_addr, mem_wdata  out  8 each  memory address and write data.
REQ-012 mem_we  out  1  memory write enable.
REQ-013 mem_rdata  in  8  memory read data, valid one cycle after mem_addr is presented.
REQ-014 busy  out  1  1 whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, ACCESS and RESP, with transitions IDLE->ACCESS (any req high), ACCESS->RESP (always), RESP->IDLE (always), and IDLE->IDLE otherwise; unused encodings go to IDLE.
REQ-016 In IDLE with exactly one req high, that requester SHALL win.
REQ-017 In IDLE with both req high, the requester not granted most recently SHALL win (round robin).
REQ-018 On the IDLE->ACCESS edge, the block SHALL latch the winner's addr, wdata, wr and identity, update the last-granted pointer, and pulse the winner's gnt high for the ACCESS cycle only.
REQ-019 In ACCESS, mem_addr and mem_wdata SHALL carry the latched values, and mem_we SHALL equal the latched wr for that single cycle.
REQ-020 mem_we SHALL be 0 in every state other than ACCESS.
REQ-021 On the ACCESS->RESP edge, the block SHALL register mem_rdata into rdata for reads and leave rdata unchanged for writes.
REQ-022 In RESP, the winner's done SHALL be high for exactly one cycle; the other done SHALL stay 0.
REQ-023 Latency SHALL be fixed: req sampled at edge N gives gnt during cycle N..N+1, done during cycle N+1..N+2, and the next grant no earlier than edge N+3.
REQ-024 mem_addr and mem_wdata SHALL hold their last latched values outside ACCESS.
REQ-025 Requester protocol: req, addr, wdata and wr are held stable until gnt is seen.
REQ-026 A req still high in the cycle after done SHALL be treated as a new request.
REQ-027 A req dropped before grant SHALL cause no access and no gnt.
REQ-028 A req arriving while busy SHALL be ignored until IDLE and SHALL then compete normally.
REQ-029 Requests SHALL NOT be queued internally; the requester's held req is the only pending record.
REQ-030 gnt0/gnt1 SHALL never be high together, and done0/done1 SHALL never be high together.

Reset
REQ-031 While reset is 0, the block SHALL force state=IDLE, gnt0=gnt1=done0=done1=0, mem_we=0, mem_addr=mem_wdata=rdata=0, busy=0, and last-granted=1 so that requester 0 wins the first tie.
REQ-032 Reset asserted in ACCESS or RESP SHALL abort the transfer: mem_we drops asynchronously and no done pulse follows after release.
REQ-033 The first grant after reset release SHALL be evaluated at the first rising edge with reset=1.

Verification
REQ-034 Write then read: req0, wr0=1, addr0=0xF3, wdata0=0x5A -> gnt0 pulse, then mem_we=1 with mem_addr=0xF3 and mem_wdata=0x5A for one cycle, then done0; a following read of 0xF3 returns rdata=0x5A with done0.
REQ-035 Tie after reset: req0 and req1 both held high -> grant order 0, 1, 0, 1 with grants 3 cycles apart and no overlapping gnt or done.
REQ-036 Single requester streaming: req1 held high for 4 reads of 0x10..0x13 -> 4 grants, all to requester 1, at cycles 0, 3, 6, 9 relative to the first grant.
REQ-037 Late arrival: req1 rises during ACCESS of a requester-0 transfer -> no gnt1 until the next IDLE; gnt1 is then issued even if req0 is still high.
REQ-038 Reset mid-write: reset=0 in the ACCESS cycle -> mem_we=0 within the same cycle, all outputs 0, and no done pulse after release.
REQ-039 Withdrawn request: req0 pulses high for a cycle while busy and falls before IDLE -> no gnt0, no memory access.
